// File: rtl/data_sink_sequencer.sv
// Issues one broadcast enable word per transaction to a bank of data sinks,
// throttled by the slowest stream, and reports completion once every stream has drained.
module data_sink_sequencer #(
  parameter int NUM_STREAMS     = 4,
  parameter int CNT_W           = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [NUM_STREAMS-1:0] cmd_drop,
  input  logic [CNT_W-1:0]       cmd_count,
  output logic                   enable_valid,
  input  logic                   enable_ready,
  output logic [NUM_STREAMS-1:0] enable_data,
  input  logic [NUM_STREAMS-1:0] last_seen,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic [CNT_W-1:0]       done_count,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t                   state_r, state_s;
  logic [NUM_STREAMS-1:0]   mask_r;
  logic [CNT_W-1:0]         count_r;
  logic [CNT_W-1:0]         issued_r;
  logic [CNT_W-1:0]         completed_r [NUM_STREAMS];
  logic [CNT_W-1:0]         completed_s [NUM_STREAMS];
  logic [CNT_W-1:0]         min_completed_s;
  logic                     all_done_s;
  logic                     window_open_s;
  logic                     cmd_fire_s;
  logic                     enable_fire_s;

  assign cmd_fire_s    = cmd_valid && cmd_ready;
  assign enable_fire_s = enable_valid && enable_ready;

  // Saturating per-stream completion update; also tells whether all streams finish this cycle
  always_comb begin
    all_done_s = 1'b1;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if ((state_r != IDLE) && last_seen[i] && (completed_r[i] < count_r)) begin
        completed_s[i] = completed_r[i] + ONE;
      end else begin
        completed_s[i] = completed_r[i];
      end
      all_done_s = all_done_s & (completed_s[i] == count_r);
    end
  end

  // Issue window from the registered counters: slowest stream bounds how far issuing runs ahead
  always_comb begin
    min_completed_s = completed_r[0];
    for (int i = 1; i < NUM_STREAMS; i++) begin
      if (completed_r[i] < min_completed_s) begin
        min_completed_s = completed_r[i];
      end else begin
        min_completed_s = min_completed_s;
      end
    end
    if (min_completed_s >= issued_r) begin
      window_open_s = 1'b1;
    end else begin
      window_open_s = ((issued_r - min_completed_s) < MAX_OUT);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_s      = state_r;
    cmd_ready    = (state_r == IDLE);
    busy         = (state_r != IDLE);
    done_valid   = (state_r == DONE);
    enable_valid = (state_r == ISSUE) && (issued_r < count_r) && window_open_s;
    enable_data  = mask_r;
    done_count   = count_r;
    case (state_r)
      IDLE: begin
        if (cmd_fire_s) begin
          state_s = (cmd_count == {CNT_W{1'b0}}) ? DONE : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (enable_fire_s && ((issued_r + ONE) == count_r)) begin
          state_s = all_done_s ? DONE : DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (all_done_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, command latch and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mask_r   <= {NUM_STREAMS{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      issued_r <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_STREAMS; i++) begin
        completed_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      state_r <= state_s;
      if (cmd_fire_s) begin
        mask_r   <= cmd_drop;
        count_r  <= cmd_count;
        issued_r <= {CNT_W{1'b0}};
        for (int i = 0; i < NUM_STREAMS; i++) begin
          completed_r[i] <= {CNT_W{1'b0}};
        end
      end else begin
        if (enable_fire_s) begin
          issued_r <= issued_r + ONE;
        end
        for (int i = 0; i < NUM_STREAMS; i++) begin
          completed_r[i] <= completed_s[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sink_sequencer.sv
// Randomized bench: sinks, host and completion consumer are modelled behaviourally;
// a transaction-level reference predicts every output each cycle.
module tb_data_sink_sequencer;
  localparam int NS = 4;
  localparam int CW = 16;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [NS-1:0] cmd_drop;
  logic [CW-1:0] cmd_count;
  logic          enable_valid;
  logic          enable_ready;
  logic [NS-1:0] enable_data;
  logic [NS-1:0] last_seen;
  logic          done_valid;
  logic          done_ready;
  logic [CW-1:0] done_count;
  logic          busy;

  data_sink_sequencer #(.NUM_STREAMS(NS), .CNT_W(CW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_drop(cmd_drop), .cmd_count(cmd_count), .enable_valid(enable_valid),
    .enable_ready(enable_ready), .enable_data(enable_data), .last_seen(last_seen),
    .done_valid(done_valid), .done_ready(done_ready), .done_count(done_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: phase 0=waiting for command, 1=issuing, 2=waiting for streams, 3=reporting
  int            m_phase;
  int            m_count;
  int            m_issued;
  int            m_comp [NS];
  logic [NS-1:0] m_mask;
  int            pend [NS];
  int            cmd_enables;
  int            n_done;
  int            n_zero;
  int            n_stall;

  function automatic int min_comp();
    int m = m_comp[0];
    for (int i = 1; i < NS; i++) if (m_comp[i] < m) m = m_comp[i];
    return m;
  endfunction

  function automatic bit all_comp();
    bit a = 1'b1;
    for (int i = 0; i < NS; i++) if (m_comp[i] != m_count) a = 1'b0;
    return a;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_issued = 0; m_mask = '0; cmd_enables = 0;
    for (int i = 0; i < NS; i++) begin m_comp[i] = 0; pend[i] = 0; end
  endtask

  initial begin
    bit exp_ev;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_drop = '0; cmd_count = '0;
    enable_ready = 1'b0; last_seen = '0; done_ready = 1'b0;
    n_done = 0; n_zero = 0; n_stall = 0;
    model_reset();
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      rst_n        = (cyc == 0) ? 1'b0 : ($urandom_range(0, 399) != 0);
      cmd_valid    = ($urandom_range(0, 9) < 6);
      cmd_drop     = NS'($urandom);
      cmd_count    = CW'($urandom_range(0, 8));
      enable_ready = ($urandom_range(0, 9) < 7);
      done_ready   = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NS; i++) begin
        if (pend[i] > 0) last_seen[i] = ($urandom_range(0, 9) < 3);
        else if (m_phase == 0) last_seen[i] = ($urandom_range(0, 9) == 0);
        else last_seen[i] = 1'b0;
      end

      exp_ev = (m_phase == 1) && (m_issued < m_count) && ((m_issued - min_comp()) < MO);
      check_eq("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
      check_eq("busy", 32'(busy), 32'(m_phase != 0));
      check_eq("done_valid", 32'(done_valid), 32'(m_phase == 3));
      check_eq("enable_valid", 32'(enable_valid), 32'(exp_ev));
      check_eq("enable_data", 32'(enable_data), 32'(m_mask));
      check_eq("done_count", 32'(done_count), 32'(m_count));
      if (m_phase == 1 && !exp_ev && m_issued < m_count) n_stall++;

      if (!rst_n) begin
        model_reset();
      end else if (m_phase == 0) begin
        if (cmd_valid) begin
          m_mask = cmd_drop; m_count = int'(cmd_count); m_issued = 0; cmd_enables = 0;
          for (int i = 0; i < NS; i++) m_comp[i] = 0;
          m_phase = (m_count == 0) ? 3 : 1;
          if (m_count == 0) n_zero++;
        end
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (last_seen[i] && m_comp[i] < m_count) m_comp[i]++;
          if (last_seen[i] && pend[i] > 0) pend[i]--;
        end
        if (m_phase == 1 && exp_ev && enable_ready) begin
          m_issued++; cmd_enables++;
          for (int i = 0; i < NS; i++) pend[i]++;
          if (m_issued == m_count) m_phase = all_comp() ? 3 : 2;
        end else if (m_phase == 2) begin
          if (all_comp()) m_phase = 3;
        end else if (m_phase == 3 && done_ready) begin
          check_eq("enables_per_cmd", 32'(cmd_enables), 32'(m_count));
          n_done++;
          m_phase = 0;
        end
      end
    end

    check_eq("commands_completed", 32'(n_done >= 20), 32'd1);
    check_eq("zero_count_seen", 32'(n_zero > 0), 32'd1);
    check_eq("window_stall_seen", 32'(n_stall > 0), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sink_sequencer.md
Name: data_sink_sequencer

Overview:
- Sequences a bank of NUM_STREAMS DataSinks that share one broadcast enable (ready_valid) channel.
- Accepts a command of {per-stream drop mask, transaction count}, issues one enable word per transaction, and counts per-stream last beats.
- Reports completion once every stream has finished all transactions.
- Sits between the host/config register block and the sinks' enable input.

Parameters:
- NUM_STREAMS, 4, number of sinks; enable word width; bit i drives the sink with ID=i
- CNT_W, 16, width of transaction count and of all internal counters
- MAX_OUTSTANDING, 2, max enable words issued ahead of the slowest stream's completed transactions (1..2^CNT_W-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_drop  in  NUM_STREAMS  bit=1: sink discards the stream; bit=0: sink forwards it
- cmd_count  in  CNT_W  number of transactions to sequence
- enable_valid  out  1  enable word valid
- enable_ready  in  1  AND of all sinks' enable.ready
- enable_data  out  NUM_STREAMS  enable word = latched cmd_drop
- last_seen  in  NUM_STREAMS  per-stream pulse: last beat handshaked at sink input (valid&&last&&ready)
- done_valid  out  1  completion record valid
- done_ready  in  1  completion consumer ready
- done_count  out  CNT_W  transactions completed (= latched count)
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; cmd_ready=1; enable_valid=0; done_valid=0; busy=0; all counters=0; enable_data/done_count=0. Reset mid-operation aborts the command immediately with no done record.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd handshake:
  - latch mask and count; clear issued and per-stream completed counters.
  - count=0: go to DONE (done_count=0, no enable issued); otherwise go to ISSUE.
- ISSUE: cmd_ready=0.
  - enable_valid=1 whenever issued<count and (issued − min_i completed_i) < MAX_OUTSTANDING; enable_data=mask.
  - Handshake increments issued.
  - enable_valid and enable_data are stable while valid&&!ready.
  - After the handshake that makes issued==count, go to DRAIN (next cycle enable_valid=0).
- DRAIN: wait until completed_i==count for all i, then go to DONE.
- DONE: done_valid=1, done_count=count. On done_ready, go to IDLE; cmd_ready=1 the following cycle.
- Completion counting (all non-IDLE states):
  - last_seen[i] increments completed_i; completed_i saturates at count.
  - Pulses while in IDLE are ignored.
  - Simultaneous pulses on several streams each count, same cycle.
- Dropped streams still produce last_seen (the sink consumes them) and are counted identically.
- Outstanding check uses registered counters. An issue handshake and a completion in the same cycle are both applied; the window is re-evaluated next cycle.
- ISSUE→DRAIN and DRAIN→DONE are evaluated in the same cycle: if all streams are already complete when the final enable handshakes, go straight to DONE.
- Latency: cmd accept → first enable_valid = 1 cycle. Final completing last_seen → done_valid = 1 cycle.
- Arithmetic: CNT_W-bit unsigned, no wrap because of saturation; min over completed_i is combinational.

Test Plan:
- NUM_STREAMS=4, cmd_drop=4'b0101, count=3, enable_ready=1, last_seen=4'b1111 two cycles after each enable → exactly 3 enable words of 0101; done_valid with done_count=3; busy falls after done handshake.
- count=5, MAX_OUTSTANDING=2, no last_seen → exactly 2 enables issued then enable_valid=0. One pulse on all streams → 1 more enable. Stream 2 lagging by one transaction → issuing stalls until stream 2 catches up.
- enable_ready held 0 for 4 cycles → enable_valid=1 and enable_data stable across all 4 cycles; issued count unchanged.
- count=0 → no enable_valid, done_valid next cycle with done_count=0.
- Streams finish at different cycles (stream 3 last) → done_valid asserted exactly 1 cycle after stream 3's final pulse; done_ready=0 for 3 cycles keeps done_valid=1 and cmd_ready=0.
- rst_n=0 during DRAIN with count=4, issued=4 → next cycle IDLE, cmd_ready=1, busy=0, no done record. A new command with count=1 then completes normally.
